// File: rtl/bus_grant_encoder_pkg.sv
// Shared definitions for the CPU bus-source grant logic.
package bus_grant_encoder_pkg;

  // Default requester count used by the datapath bus.
  localparam int unsigned BUS_SOURCES = 32;

  // Grant FSM state encoding.
  typedef enum logic [0:0] {
    GNT_IDLE  = 1'b0,
    GNT_OWNED = 1'b1
  } gnt_state_e;

endpackage

// File: rtl/bus_grant_encoder_rr_priority_pick.sv
// Combinational winner picker: lowest set request at or above ptr, wrapping
// from N-1 to 0. With ROUND_ROBIN=0 the pointer is forced to 0, which gives
// plain lowest-index priority.
module rr_priority_pick
  import bus_grant_encoder_pkg::*;
#(
  parameter int unsigned N           = BUS_SOURCES,
  parameter int unsigned W           = (N > 1) ? $clog2(N) : 1,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner_idx,
  output logic         any_req,
  output logic         multi_req
);

  logic [W-1:0]   eff_ptr;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [W:0]     offset;
  logic [W:0]     sum;
  logic           found;

  // Rotate requests so that bit 0 is the ptr position, then find the first set bit.
  always_comb begin
    eff_ptr = ROUND_ROBIN ? ptr : '0;
    req_dbl = {req, req};
    req_rot = N'(req_dbl >> eff_ptr);
    offset  = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = (W+1)'(k);
      end
    end
    // Undo the rotation; ptr < N so a single subtract is a full modulo.
    sum        = {1'b0, eff_ptr} + offset;
    winner_idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
  end

  // Request presence flags for arbitration and collision reporting.
  always_comb begin
    any_req   = |req;
    multi_req = ($countones(req) > 1);
  end

endmodule

// File: rtl/bus_grant_encoder.sv
// Registered bus-source selector: arbitrates among N requesters, holds the
// grant until release or owner request drop, reports multi-request arbitrations.
// The release input is named bus_release because 'release' is a reserved word.
module bus_grant_encoder
  import bus_grant_encoder_pkg::*;
#(
  parameter int unsigned N           = BUS_SOURCES,
  parameter bit          ROUND_ROBIN = 1'b1,
  localparam int unsigned W          = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic         bus_release,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid,
  output logic         collision
);

  gnt_state_e   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic         valid_q, valid_d;
  logic         coll_q, coll_d;

  logic [W-1:0] winner_idx;
  logic         any_req;
  logic         multi_req;
  logic         tenure_end;

  rr_priority_pick #(
    .N          (N),
    .W          (W),
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .winner_idx(winner_idx),
    .any_req   (any_req),
    .multi_req (multi_req)
  );

  // Tenure ends once on release or owner request drop (both together count once).
  assign tenure_end = (state_q == GNT_OWNED) && (bus_release || !(|(req & onehot_q)));

  // FSM state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= GNT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GNT_IDLE:  if (any_req) state_d = GNT_OWNED;
      GNT_OWNED: if (tenure_end) state_d = GNT_IDLE;
      default:   state_d = GNT_IDLE;
    endcase
  end

  // Next values for the grant registers and the rotation pointer.
  always_comb begin
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    coll_d   = 1'b0;
    case (state_q)
      GNT_IDLE: begin
        if (any_req) begin
          idx_d    = winner_idx;
          onehot_d = N'(1) << winner_idx;
          valid_d  = 1'b1;
          coll_d   = multi_req;
        end
      end
      GNT_OWNED: begin
        if (tenure_end) begin
          idx_d    = '0;
          onehot_d = '0;
          valid_d  = 1'b0;
          if (ROUND_ROBIN) begin
            ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Output and pointer registers; outputs come straight from these flops.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      coll_q   <= coll_d;
    end
  end

  assign grant_onehot = onehot_q;
  assign grant_idx    = idx_q;
  assign grant_valid  = valid_q;
  assign collision    = coll_q;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Bench for bus_grant_encoder: three instances (N=32 round-robin, N=32 fixed,
// N=24 round-robin) share stimulus; a reference model queues expected outputs
// each edge and a negedge monitor compares them.
module tb_bus_grant_encoder;

  typedef struct packed {
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] oh;
    logic        coll;
  } exp_t;

  typedef exp_t [2:0] exp3_t;

  typedef struct {
    int owner;
    int ptr;
  } mstate_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] req = '0;
  logic        bus_release = 1'b0;

  logic [31:0] rr_oh, fx_oh;
  logic [23:0] n24_oh;
  logic [4:0]  rr_idx, fx_idx, n24_idx;
  logic        rr_valid, fx_valid, n24_valid;
  logic        rr_coll, fx_coll, n24_coll;

  int tests = 0;
  int fails = 0;

  exp3_t   sbq[$];
  mstate_t ms[3];
  int      mn[3] = '{32, 32, 24};
  bit      mrr[3] = '{1'b1, 1'b0, 1'b1};

  bus_grant_encoder #(.N(32), .ROUND_ROBIN(1'b1)) u_rr (
    .clock(clock), .clear(clear), .req(req), .bus_release(bus_release),
    .grant_onehot(rr_oh), .grant_idx(rr_idx), .grant_valid(rr_valid), .collision(rr_coll)
  );

  bus_grant_encoder #(.N(32), .ROUND_ROBIN(1'b0)) u_fx (
    .clock(clock), .clear(clear), .req(req), .bus_release(bus_release),
    .grant_onehot(fx_oh), .grant_idx(fx_idx), .grant_valid(fx_valid), .collision(fx_coll)
  );

  bus_grant_encoder #(.N(24), .ROUND_ROBIN(1'b1)) u_n24 (
    .clock(clock), .clear(clear), .req(req[23:0]), .bus_release(bus_release),
    .grant_onehot(n24_oh), .grant_idx(n24_idx), .grant_valid(n24_valid),
    .collision(n24_coll)
  );

  always #5 clock = ~clock;

  // Reference behaviour: owner is -1 when idle; winner found by scanning
  // requester numbers starting from ptr (or 0 in fixed mode).
  function automatic void model_step(input int n, input bit rr, input logic [31:0] r,
                                     input bit rel, input mstate_t si,
                                     output mstate_t so, output exp_t e);
    int cnt;
    int win;
    int j;
    so     = si;
    e.coll = 1'b0;
    if (si.owner >= 0) begin
      if (rel || !r[si.owner]) begin
        if (rr) so.ptr = (si.owner + 1) % n;
        so.owner = -1;
      end
    end else begin
      cnt = 0;
      win = -1;
      for (int k = 0; k < n; k++) begin
        j = rr ? (si.ptr + k) % n : k;
        if (r[j]) begin
          cnt++;
          if (win < 0) win = j;
        end
      end
      if (cnt > 0) begin
        so.owner = win;
        e.coll   = (cnt > 1);
      end
    end
    e.valid = (so.owner >= 0);
    e.idx   = (so.owner >= 0) ? 5'(so.owner) : 5'd0;
    e.oh    = (so.owner >= 0) ? (32'd1 << so.owner) : 32'd0;
  endfunction

  // Model advances on each edge; a clear resets it and drops pending expectations.
  always @(posedge clock or posedge clear) begin
    exp3_t   e3;
    mstate_t nxt;
    exp_t    e;
    if (clear) begin
      for (int i = 0; i < 3; i++) ms[i] = '{-1, 0};
      sbq.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        model_step(mn[i], mrr[i], req, bus_release, ms[i], nxt, e);
        ms[i] = nxt;
        e3[i] = e;
      end
      sbq.push_back(e3);
    end
  end

  // Monitor: compare all instances against the queued expectation (reset values if none).
  always @(negedge clock) begin
    exp3_t exp3;
    exp_t  got[3];
    got[0] = '{rr_valid, rr_idx, rr_oh, rr_coll};
    got[1] = '{fx_valid, fx_idx, fx_oh, fx_coll};
    got[2] = '{n24_valid, n24_idx, {8'd0, n24_oh}, n24_coll};
    if (sbq.size() > 0) exp3 = sbq.pop_front();
    else exp3 = '0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got[i] !== exp3[i]) begin
        fails++;
        $display("FAIL sb_dut%0d t=%0t got v=%b idx=%0d oh=%h c=%b want v=%b idx=%0d oh=%h c=%b",
                 i, $time, got[i].valid, got[i].idx, got[i].oh, got[i].coll,
                 exp3[i].valid, exp3[i].idx, exp3[i].oh, exp3[i].coll);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_rr_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 8; c++) begin
      if (rr_valid) begin
        idx = int'(rr_idx);
        return;
      end
      @(negedge clock);
    end
    tests++;
    fails++;
    $display("FAIL rr_grant_timeout got=none want=grant within 8 cycles");
  endtask

  initial begin
    int got;
    int seq[3];
    seq = '{0, 31, 0};

    // Reset with a request held: outputs stay zero, grant follows one edge later.
    req = 32'h0000_0004;
    cyc(2);
    check("reset_valid", {31'd0, rr_valid}, 32'd0);
    check("reset_onehot", rr_oh, 32'd0);
    clear = 1'b0;
    cyc(1);
    check("first_idx", {27'd0, rr_idx}, 32'd2);
    check("first_onehot", rr_oh, 32'h4);
    check("first_coll", {31'd0, rr_coll}, 32'd0);
    req = '0;
    cyc(2);

    // Alternating tenures between sources 0 and 31.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    req = 32'h8000_0001;
    for (int t = 0; t < 3; t++) begin
      wait_rr_grant(got);
      check("rr_alt_idx", got, seq[t]);
      check("rr_alt_coll", {31'd0, rr_coll}, 32'd1);
      check("fx_idx", {26'd0, fx_valid, fx_idx}, 32'h20);
      bus_release = 1'b1;
      cyc(1);
      bus_release = 1'b0;
      check("rr_idle_gap", {31'd0, rr_valid}, 32'd0);
    end
    req = '0;
    cyc(2);

    // Owner drop without release; other request waits one idle cycle.
    req = 32'h20;
    cyc(1);
    check("own5_idx", {27'd0, rr_idx}, 32'd5);
    req = 32'h220;
    cyc(1);
    check("own5_hold", {27'd0, rr_idx}, 32'd5);
    req = 32'h200;
    cyc(1);
    check("drop_idle", {31'd0, rr_valid}, 32'd0);
    cyc(1);
    check("own9_idx", {27'd0, rr_idx}, 32'd9);
    req = '0;
    cyc(2);

    // Single-hot sweep on the N=24 instance.
    for (int i = 0; i < 24; i++) begin
      req = 32'd1 << i;
      cyc(1);
      check("n24_sweep_idx", {27'd0, n24_idx}, 32'(i));
      req = '0;
      cyc(1);
    end
    cyc(1);

    // Asynchronous clear mid-tenure, then pointer must be back at 0.
    req = 32'h80;
    cyc(1);
    check("own7_idx", {27'd0, rr_idx}, 32'd7);
    #1 clear = 1'b1;
    #1;
    check("async_clear_valid", {31'd0, rr_valid}, 32'd0);
    check("async_clear_onehot", rr_oh, 32'd0);
    clear = 1'b0;
    req = 32'h0000_0180;
    cyc(1);
    check("post_clear_idx", {26'd0, rr_valid, rr_idx}, 32'h27);
    req = '0;
    cyc(2);

    // Random traffic, checked by the scoreboard.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0) req = $urandom & $urandom & $urandom;
      bus_release = ($urandom_range(3) == 0);
      cyc(1);
    end
    req = '0;
    bus_release = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_grant_encoder.md
# bus_grant_encoder

Parametrised, registered one-hot-to-binary bus-source selector with arbitration. Takes N bus-drive requests from datapath registers and special sources, grants exactly one per bus tenure, and presents the winner as both a one-hot select and an encoded index for the bus multiplexer. It replaces the purely combinational 32-to-5 encoder in front of the CPU bus. It adds a round-robin or fixed-priority policy, grant hold until release, and collision reporting.

## Interface
- `N`, 32: number of requesters; legal range 1–64.
- `W`, `$clog2(N)` (minimum 1): index width; derived, never overridden.
- `ROUND_ROBIN`, 1: 1 = rotating priority; 0 = fixed priority, lowest index wins.

- `clock`  in  1  single system clock, rising-edge.
- `clear`  in  1  asynchronous, active-high reset.
- `req`  in  N  bus-drive requests; level-sensitive, one bit per source.
- `release`  in  1  current owner ends its tenure; single-cycle pulse.
- `grant_onehot`  out  N  registered one-hot bus select; all-zero when idle.
- `grant_idx`  out  W  registered binary index of the owner.
- `grant_valid`  out  1  registered; high while a grant is held.
- `collision`  out  1  registered; high for one cycle when an arbitration found more than one request.

## Operation
- State machine with two states, IDLE and OWNED. Reset state is IDLE.
- **IDLE:**
  - If `req` is zero, stay in IDLE and keep all grant outputs zero.
  - Otherwise pick a winner and load the `grant_*` registers, `collision` (popcount(req) > 1) and OWNED.
- **Winner selection:**
  - Fixed mode: lowest set index.
  - Round-robin mode: first set bit at or above pointer `ptr`, scanning upward and wrapping from N-1 to 0.
- **OWNED:**
  - Outputs hold stable; changes on other `req` bits are ignored.
  - The tenure ends on `release`=1, or when `req[grant_idx]` drops to 0, whichever comes first.
  - At the end of tenure, return to IDLE and clear the grant outputs.
  - In round-robin mode, `ptr` ← (grant_idx+1) mod N, so N-1 wraps to 0.
- **`ptr`:** W bits, reset 0. It only updates at the end of a tenure and is unused in fixed mode.
- `release` in IDLE is ignored.
- `collision` is cleared on every cycle except the one immediately after an arbitration.
- When N is not a power of two, `grant_idx` never exceeds N-1.
- When N=1, W=1 and `grant_idx` is always 0.
- `grant_onehot` always equals (1 << grant_idx) when `grant_valid` is high; otherwise it is zero.

## Timing
- Reset values: `grant_onehot`=0, `grant_idx`=0, `grant_valid`=0, `collision`=0, `ptr`=0, state IDLE.
- `clear` takes effect immediately, independent of `clock`. Asserting it mid-tenure drops the grant with no `ptr` update.
- Request-to-grant latency is 1 cycle. A request seen on edge k produces `grant_valid` after edge k.
- Release-to-idle latency is 1 cycle. A new arbitration follows on the next edge, so the minimum gap between tenures is one idle cycle, during which nothing drives the bus.
- If `release` and a drop of the owner's `req` occur in the same cycle, the tenure ends once; it is not counted twice.
- All outputs come directly from registers, with no combinational path from input to output.

## Structure
- Shared CPU package holds:
  - the state encoding (`GNT_IDLE`, `GNT_OWNED`);
  - `BUS_SOURCES` = 32, the default requester count used by the datapath.
- One sub-module, `rr_priority_pick`:
  - combinational;
  - inputs: `req`, `ptr`, `ROUND_ROBIN`;
  - outputs: winner index, any-request flag, multi-request flag.
- The top level keeps the FSM, the `ptr` register and the output registers.

## Test plan
- Reset while `req`=32'h0000_0004 held → all outputs 0. After `clear` falls, one edge later `grant_idx`=2, `grant_onehot`=32'h4, `grant_valid`=1, `collision`=0.
- Round-robin, `req`=32'h8000_0001 held, `release` pulsed once per tenure → grants alternate idx 0, 31, 0, with one idle cycle between. `collision`=1 after each arbitration.
- Fixed mode, same stimulus → idx 0 granted every tenure. Round-robin pointer wrap: owner 31 released → `ptr`=0.
- While OWNED at idx 5, assert `req[9]`, then drop `req[5]` without `release` → grant clears next edge, then idx 9 is granted one idle cycle later.
- N=24 (W=5), `req`=24'h80_0000 → `grant_idx`=23. Sweep every single-hot input 0..23 → index equals bit position.
- `clear` pulsed between clock edges while OWNED at idx 7 → outputs zero immediately. After reset, with `req`=32'h0000_0180, round-robin grants idx 7 first, showing `ptr` returned to 0.
